// File: rtl/bin_to_seg7_digits.sv
// ---------------------------------------------------------------------------
// bin_to_seg7_digits
//
// Sequential binary-to-decimal converter (shift-add-3 / double dabble) that
// produces four active-low 7-segment patterns for the display multiplexer.
// seg0 is the ones digit and seg3 is the thousands digit. The previous
// result stays on seg0..seg3 until a new conversion completes.
//
// FSM: IDLE -> SHIFT (WIDTH cycles) -> LATCH -> IDLE.
//
// Handshake: start is a request that is looked at only in IDLE. The edge that
// sees start=1 in IDLE accepts the request and captures bin_in. After that,
// start and bin_in are ignored until the FSM is back in IDLE. Requests are not
// queued. done pulses for exactly one cycle, and seg0..seg3 already carry the
// new result during that cycle.
//
// Parameters:
//   WIDTH   bit width of bin_in, legal range 4..14 (one shift cycle per bit)
//
// Ports:
//   clk     clock
//   rst_n   asynchronous active-low reset
//   start   conversion request (sampled in IDLE only)
//   bin_in  unsigned value to convert, captured on the accepting edge
//   busy    high while the FSM is not in IDLE
//   done    one-cycle pulse when seg0..seg3 take the new result
//   seg0..3 digit patterns {g,f,e,d,c,b,a}, active-low (seg0 = ones)
//
// Build option:
//   LZ_BLANK_EN  when defined, leading zero digits are blanked, scanning from
//                seg3 downward. seg0 is always shown, and overflow dashes are
//                never blanked.
// ---------------------------------------------------------------------------
module bin_to_seg7_digits #(
    parameter int WIDTH = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] bin_in,
    output logic             busy,
    output logic             done,
    output logic [6:0]       seg0,
    output logic [6:0]       seg1,
    output logic [6:0]       seg2,
    output logic [6:0]       seg3
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [3:0] CNT_LAST  = 4'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] shift_q;
    logic [15:0]      bcd_q;
    logic [3:0]       cnt_q;
    logic             ovf_q;
    logic             done_q;
    logic [6:0]       seg0_q, seg1_q, seg2_q, seg3_q;

    logic             ovf_in;
    logic [15:0]      bcd_adj;
    logic [15+WIDTH:0] shifted;
    logic [6:0]       seg0_d, seg1_d, seg2_d, seg3_d;

    function automatic logic [6:0] decode_digit(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0010000;
            default: p = SEG_DASH;
        endcase
        return p;
    endfunction

    // Values above 9999 cannot be shown in four digits.
    // This is only reachable when WIDTH is 14.
    assign ovf_in = (32'(bin_in) > 32'd9999);

    // Add 3 to each nibble that is 5 or more, then shift {bcd, bin} left by one.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        shifted = {bcd_adj, shift_q} << 1;
    end

    // Final digit patterns, computed from the finished BCD value during LATCH.
    always_comb begin
        seg0_d = decode_digit(bcd_q[3:0]);
        seg1_d = decode_digit(bcd_q[7:4]);
        seg2_d = decode_digit(bcd_q[11:8]);
        seg3_d = decode_digit(bcd_q[15:12]);
`ifdef LZ_BLANK_EN
        if (bcd_q[15:12] == 4'd0) begin
            seg3_d = SEG_BLANK;
        end
        if (bcd_q[15:8] == 8'd0) begin
            seg2_d = SEG_BLANK;
        end
        if (bcd_q[15:4] == 12'd0) begin
            seg1_d = SEG_BLANK;
        end
`endif
        if (ovf_q) begin
            seg0_d = SEG_DASH;
            seg1_d = SEG_DASH;
            seg2_d = SEG_DASH;
            seg3_d = SEG_DASH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            seg0_q  <= SEG_BLANK;
            seg1_q  <= SEG_BLANK;
            seg2_q  <= SEG_BLANK;
            seg3_q  <= SEG_BLANK;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        shift_q <= bin_in;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        ovf_q   <= ovf_in;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    {bcd_q, shift_q} <= shifted;
                    cnt_q            <= cnt_q + 4'd1;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= LATCH;
                    end
                end
                LATCH: begin
                    seg0_q  <= seg0_d;
                    seg1_q  <= seg1_d;
                    seg2_q  <= seg2_d;
                    seg3_q  <= seg3_d;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign seg0 = seg0_q;
    assign seg1 = seg1_q;
    assign seg2 = seg2_q;
    assign seg3 = seg3_q;

endmodule
